// File: rtl/alu_pkg.sv
// Shared definitions for the multi-byte ALU sequencer: byte-ALU opcodes and
// sequencer state encoding.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } seq_state_e;

endpackage

// File: rtl/alu_multibyte_seq.sv
// Multi-byte operation sequencer: walks an external combinational 8-bit ALU
// across NBYTES bytes, chaining carry/shift bits through a link register.
module alu_multibyte_seq
    import alu_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  In_valid,
    output logic                  In_ready,
    input  logic [8*NBYTES-1:0]   Op_A,
    input  logic [8*NBYTES-1:0]   Op_B,
    input  logic [2:0]            Opcode,
    output logic                  Out_valid,
    input  logic                  Out_ready,
    output logic [8*NBYTES-1:0]   Result,
    output logic                  Carry_out,
    output logic                  Zero,
    output logic                  Negative,
    output logic [7:0]            Alu_A,
    output logic [7:0]            Alu_B,
    output logic [2:0]            Alu_Opcode,
    output logic                  Alu_Carry_in,
    input  logic [7:0]            Alu_Result,
    input  logic                  Alu_Carry_out
);

    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned IW = $clog2(NBYTES);

    seq_state_e        state_q;
    logic [W-1:0]      a_q, b_q, res_q;
    logic [2:0]        op_q;
    logic [IW-1:0]     idx_q;
    logic              link_q;
    logic              cout_q;

    logic [7:0]        byte_res;
    logic              link_nxt;
    logic              carry_fin;
    logic              last_byte;
    logic [7:0]        sel_a, sel_b;

    assign sel_a     = a_q[{idx_q, 3'b000} +: 8];
    assign sel_b     = b_q[{idx_q, 3'b000} +: 8];
    // SHR walks downwards, everything else upwards.
    assign last_byte = (op_q == OP_SHR) ? (idx_q == '0) : (idx_q == IW'(NBYTES - 1));

    always_comb begin
        Alu_A        = 8'h00;
        Alu_B        = 8'h00;
        Alu_Opcode   = 3'b000;
        Alu_Carry_in = 1'b0;
        byte_res     = Alu_Result;
        link_nxt     = 1'b0;
        carry_fin    = 1'b0;
        if (state_q == S_RUN) begin
            Alu_A = sel_a;
            Alu_B = sel_b;
            unique case (op_q)
                OP_ADD: begin
                    Alu_Carry_in = link_q;
                    link_nxt     = Alu_Carry_out;
                    carry_fin    = Alu_Carry_out;
                end
                OP_SUB: begin
                    // A + ~B + 1; a clear final carry means a borrow occurred.
                    Alu_B        = ~sel_b;
                    Alu_Carry_in = link_q;
                    link_nxt     = Alu_Carry_out;
                    carry_fin    = ~Alu_Carry_out;
                end
                OP_SHL: begin
                    Alu_Opcode = OP_SHL;
                    byte_res   = Alu_Result | {7'b0, link_q};
                    link_nxt   = Alu_Carry_out;
                    carry_fin  = Alu_Carry_out;
                end
                OP_SHR: begin
                    Alu_Opcode = OP_SHR;
                    byte_res   = Alu_Result | {link_q, 7'b0};
                    link_nxt   = Alu_Carry_out;
                    carry_fin  = Alu_Carry_out;
                end
                default: begin
                    Alu_Opcode = op_q;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= OP_ADD;
            idx_q   <= '0;
            link_q  <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (In_valid) begin
                        a_q     <= Op_A;
                        b_q     <= Op_B;
                        op_q    <= Opcode;
                        idx_q   <= (Opcode == OP_SHR) ? IW'(NBYTES - 1) : '0;
                        link_q  <= (Opcode == OP_SUB);
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    res_q[{idx_q, 3'b000} +: 8] <= byte_res;
                    link_q <= link_nxt;
                    idx_q  <= (op_q == OP_SHR) ? idx_q - 1'b1 : idx_q + 1'b1;
                    if (last_byte) begin
                        cout_q  <= carry_fin;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (Out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign In_ready  = (state_q == S_IDLE);
    assign Out_valid = (state_q == S_DONE);
    assign Result    = res_q;
    assign Carry_out = cout_q;
    assign Zero      = (res_q == '0);
    assign Negative  = res_q[W-1];

endmodule

// File: tb/tb_alu_multibyte_seq.sv
// Scoreboard bench for alu_multibyte_seq with a behavioural 8-bit ALU attached.
module tb_alu_multibyte_seq;

    localparam int unsigned NBYTES = 4;
    localparam int unsigned W      = 8 * NBYTES;
    localparam int          PERIOD = 10;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          In_valid = 1'b0;
    logic          In_ready;
    logic [W-1:0]  Op_A = '0, Op_B = '0;
    logic [2:0]    Opcode = 3'b000;
    logic          Out_valid;
    logic          Out_ready = 1'b0;
    logic [W-1:0]  Result;
    logic          Carry_out, Zero, Negative;
    logic [7:0]    Alu_A, Alu_B, Alu_Result;
    logic [2:0]    Alu_Opcode;
    logic          Alu_Carry_in, Alu_Carry_out;

    always #(PERIOD / 2) Clk = ~Clk;

    alu_multibyte_seq #(.NBYTES(NBYTES)) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .In_valid     (In_valid),
        .In_ready     (In_ready),
        .Op_A         (Op_A),
        .Op_B         (Op_B),
        .Opcode       (Opcode),
        .Out_valid    (Out_valid),
        .Out_ready    (Out_ready),
        .Result       (Result),
        .Carry_out    (Carry_out),
        .Zero         (Zero),
        .Negative     (Negative),
        .Alu_A        (Alu_A),
        .Alu_B        (Alu_B),
        .Alu_Opcode   (Alu_Opcode),
        .Alu_Carry_in (Alu_Carry_in),
        .Alu_Result   (Alu_Result),
        .Alu_Carry_out(Alu_Carry_out)
    );

    // Behavioural 8-bit ALU core
    always_comb begin
        logic [8:0] s;
        s = 9'h000;
        case (Alu_Opcode)
            3'b000: s = {1'b0, Alu_A} + {1'b0, Alu_B} + {8'h00, Alu_Carry_in};
            3'b001: s = {1'b0, Alu_A} - {1'b0, Alu_B};
            3'b010: s = {1'b0, Alu_A & Alu_B};
            3'b011: s = {1'b0, Alu_A | Alu_B};
            3'b100: s = {1'b0, Alu_A ^ Alu_B};
            3'b101: s = {1'b0, ~Alu_A};
            3'b110: s = {Alu_A[7], Alu_A[6:0], 1'b0};
            default: s = {Alu_A[0], 1'b0, Alu_A[7:1]};
        endcase
        Alu_Result    = s[7:0];
        Alu_Carry_out = s[8];
    end

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        time          t_acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   seen = 0;
    bit   rand_ready = 0;
    logic [W-1:0] hold_res;
    logic         hold_c;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: whole-word arithmetic, no byte decomposition.
    function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [2:0] op,
                                      output logic [W-1:0] r, output logic c);
        logic [W:0] wide;
        c = 1'b0;
        case (op)
            3'b000: begin wide = {1'b0, a} + {1'b0, b}; r = wide[W-1:0]; c = wide[W]; end
            3'b001: begin r = a - b; c = (a < b); end
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b100: r = a ^ b;
            3'b101: r = ~a;
            3'b110: begin r = a << 1; c = a[W-1]; end
            default: begin r = a >> 1; c = a[0]; end
        endcase
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        exp_t e;
        int   n = 0;
        @(negedge Clk);
        while (!In_ready && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (!In_ready) begin
            chk("in_ready_timeout", {31'b0, In_ready}, 1);
            return;
        end
        Op_A = a; Op_B = b; Opcode = op; In_valid = 1'b1;
        @(posedge Clk);
        ref_model(a, b, op, e.res, e.c);
        e.t_acc = $time;
        q.push_back(e);
        #1;
        In_valid = 1'b0;
        Op_A = $urandom; Op_B = $urandom; Opcode = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!Out_valid && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (!Out_valid) chk("out_valid_timeout", {31'b0, Out_valid}, 1);
    endtask

    always @(posedge Clk) begin
        if (rand_ready) begin
            #1 Out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: checks latency on first sight, stability while held, values on transfer
    always @(negedge Clk) begin
        if (!Rst_n) begin
            seen = 0;
        end else if (Out_valid) begin
            chk("in_ready_in_done", {31'b0, In_ready}, 0);
            if (q.size() == 0) begin
                chk("unexpected_output", 0, 1);
            end else begin
                if (!seen) begin
                    seen = 1;
                    hold_res = Result;
                    hold_c = Carry_out;
                    chk("latency", W'($time - q[0].t_acc), W'(NBYTES * PERIOD + PERIOD / 2));
                end else begin
                    chk("stable_result", Result, hold_res);
                    chk("stable_carry", {31'b0, Carry_out}, {31'b0, hold_c});
                end
                if (Out_ready) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("result", Result, e.res);
                    chk("carry_out", {31'b0, Carry_out}, {31'b0, e.c});
                    chk("zero", {31'b0, Zero}, {31'b0, (e.res == '0)});
                    chk("negative", {31'b0, Negative}, {31'b0, e.res[W-1]});
                    seen = 0;
                end
            end
        end
    end

    initial begin
        int n;
        #3;
        chk("rst_out_valid", {31'b0, Out_valid}, 0);
        chk("rst_in_ready", {31'b0, In_ready}, 1);
        chk("rst_result", Result, 0);
        chk("rst_alu_a", {24'b0, Alu_A}, 0);
        #(2 * PERIOD);
        Rst_n = 1'b1;

        // Directed cases with Out_ready held high throughout
        Out_ready = 1'b1;
        send(32'h0000_00FF, 32'h0000_0001, 3'b000);
        send(32'hFFFF_FFFF, 32'h0000_0001, 3'b000);
        send(32'h0000_0000, 32'h0000_0001, 3'b001);
        send(32'h0000_0005, 32'h0000_0003, 3'b001);
        send(32'h8000_8001, 32'h0000_0000, 3'b110);
        send(32'h0001_0001, 32'h0000_0000, 3'b111);
        send(32'h1234_5678, 32'h0F0F_F0F0, 3'b010);
        send(32'h1234_5678, 32'h0F0F_F0F0, 3'b011);
        send(32'hA5A5_0000, 32'h0000_0000, 3'b101);

        // Stall in DONE with In_valid held high
        n = 0;
        while (q.size() != 0 && n < 200) begin @(negedge Clk); n++; end
        Out_ready = 1'b0;
        send(32'hCAFE_F00D, 32'h1111_2222, 3'b100);
        @(negedge Clk);
        wait_valid();
        In_valid = 1'b1; Op_A = 32'h0000_0001; Op_B = 32'h0000_0001; Opcode = 3'b000;
        repeat (3) @(negedge Clk);
        Out_ready = 1'b1;
        In_valid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("post_done_out_valid", {31'b0, Out_valid}, 0);
        chk("post_done_in_ready", {31'b0, In_ready}, 1);
        chk("post_done_queue", W'(q.size()), 0);

        // Reset during byte 2 of an ADD
        send(32'h1357_9BDF, 32'h2468_ACE0, 3'b000);
        @(posedge Clk);
        @(posedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        chk("midrun_out_valid", {31'b0, Out_valid}, 0);
        chk("midrun_in_ready", {31'b0, In_ready}, 1);
        chk("midrun_result", Result, 0);
        chk("midrun_alu_opcode", {29'b0, Alu_Opcode}, 0);
        q.delete();
        seen = 0;
        @(negedge Clk);
        #3 Rst_n = 1'b1;
        send(32'hF0F0_F0F0, 32'hFFFF_FFFF, 3'b100);

        // Randomised traffic with random back-pressure
        rand_ready = 1;
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            b = $urandom;
            if (i % 10 == 3) a = '1;
            if (i % 10 == 7) b = '0;
            send(a, b, 3'($urandom_range(0, 7)));
        end

        n = 0;
        while (q.size() != 0 && n < 500) begin @(negedge Clk); n++; end
        chk("drain_queue", W'(q.size()), 0);
        rand_ready = 0;
        #(2 * PERIOD);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_multibyte_seq.md
Name: alu_multibyte_seq

Overview:
- Multi-byte operation sequencer. It is the initiator side of the 8-bit ALU byte interface.
- Accepts NBYTES-wide operands and an opcode over a valid/ready handshake.
- Drives the combinational 8-bit ALU one byte per cycle, chaining carry/shift bits between bytes.
- Returns the full-width result and flags over a second valid/ready handshake. Used wherever the datapath needs 16/32-bit arithmetic built from the 8-bit ALU.

Parameters:
NBYTES, 4, operand/result width in bytes (>=2); W = 8*NBYTES

Ports:
Clk  input  1  clock, rising edge
Rst_n  input  1  asynchronous active-low reset
In_valid  input  1  request valid
In_ready  output  1  sequencer idle, can accept
Op_A  input  W  operand A
Op_B  input  W  operand B
Opcode  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT(A), 110 SHL, 111 SHR
Out_valid  output  1  result valid
Out_ready  input  1  consumer accepts result
Result  output  W  full-width result
Carry_out  output  1  final carry / borrow / shifted-out bit
Zero  output  1  Result == 0
Negative  output  1  Result[W-1]
Alu_A  output  8  byte operand A to ALU
Alu_B  output  8  byte operand B to ALU
Alu_Opcode  output  3  ALU opcode
Alu_Carry_in  output  1  ALU carry in
Alu_Result  input  8  ALU byte result (combinational, same cycle)
Alu_Carry_out  input  1  ALU carry out (combinational, same cycle)

Behaviour:
- One clock (Clk); reset is asynchronous and active-low (Rst_n).
- Reset state:
  - state=IDLE; Result, Carry_out and link register = 0.
  - Out_valid=0; In_ready=1 (decoded from state).
  - Alu_* outputs = 0.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - In_ready=1.
  - On In_valid: capture Op_A, Op_B, Opcode; go to RUN.
  - Byte index starts at 0, except SHR, which starts at NBYTES-1.
  - Link bit starts at 1 for SUB, 0 otherwise.
- RUN: exactly NBYTES cycles, one byte per cycle. Alu_A and Alu_B carry the indexed bytes of the captured operands. Per-opcode rules:
  - ADD: Alu_Opcode=000; Alu_Carry_in=link; result byte = Alu_Result; link <= Alu_Carry_out.
  - SUB: computed as A + ~B + 1. Alu_Opcode=000; Alu_B = ~B byte; Alu_Carry_in=link. Final Carry_out = ~link, so 1 means borrow.
  - AND/OR/XOR/NOT: Alu_Opcode = captured opcode; Alu_Carry_in=0; result byte = Alu_Result; Carry_out=0.
  - SHL: bytes LSB first; Alu_Opcode=110. Result byte = Alu_Result | {7'b0, link}; link <= Alu_Carry_out (that byte's old bit7). Final Carry_out = A[W-1].
  - SHR: bytes MSB first; Alu_Opcode=111. Result byte = Alu_Result | {link, 7'b0}; link <= Alu_Carry_out (old bit0). Final Carry_out = A[0].
- Register timing: the result byte and link are registered at the end of each RUN cycle. After the last byte, Carry_out is registered and the state goes to DONE.
- DONE:
  - Out_valid=1; Result, Carry_out, Zero and Negative are stable.
  - In_ready=0; In_valid is ignored.
  - On Out_ready: go to IDLE. Out_valid drops the next cycle.
- Outside RUN, Alu_* outputs are 0.
- Zero and Negative are combinational from the Result register.
- Latency: with accept at edge T, Out_valid goes high after edge T+NBYTES.
- Throughput: one op per NBYTES+2 cycles minimum. No accept occurs in the same cycle as output completion.
- Boundary rules:
  - Out_ready held high before DONE has no effect.
  - Operand inputs may change after accept without affecting the result.
  - Arithmetic wraps modulo 2^W.
  - Rst_n asserted mid-RUN or in DONE immediately returns to the reset state; the partial result is discarded and Out_valid drops asynchronously.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams (OP_ADD..OP_SHR).
  - Sequencer state encoding (S_IDLE, S_RUN, S_DONE).
- Byte index counter width: $clog2(NBYTES).
- No sub-module required. Byte select/insert muxes stay inline.
- The ALU itself is external, connected at the parent level.

Test Plan (NBYTES=4; bench connects the team's 8-bit ALU core to the Alu_* ports):
- ADD 0x000000FF + 0x00000001 -> Result 0x00000100, Carry_out 0, Zero 0; Out_valid exactly 4 cycles after accept.
- ADD 0xFFFFFFFF + 0x00000001 -> Result 0x00000000, Carry_out 1, Zero 1, Negative 0.
- SUB 0x00000000 - 0x00000001 -> Result 0xFFFFFFFF, Carry_out 1, Negative 1. SUB 5 - 3 -> Result 2, Carry_out 0.
- SHL 0x80008001 -> Result 0x00010002, Carry_out 1. SHR 0x00010001 -> Result 0x00008000, Carry_out 1.
- Out_ready low for 3 cycles in DONE with In_valid high -> Result/flags stable, In_ready 0, no new capture. Out_ready=1 -> IDLE next cycle.
- Rst_n pulsed low during byte 2 of an ADD -> Out_valid 0, In_ready 1, Result 0. A following XOR 0xF0F0F0F0 ^ 0xFFFFFFFF -> Result 0x0F0F0F0F, Carry_out 0.
